// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: NCH independent programmable clock dividers. New settings are shadowed and only
// take effect on a terminal count, an idle slot, or a global start pulse.
module clkdiv_ctrl #(
    parameter int unsigned NCH = 4,
    parameter int unsigned W   = 16
) (
    input  logic                                   iclk,
    input  logic                                   rst,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [W-1:0]                           cfg_div,
    input  logic                                   cfg_en,
    input  logic                                   start,
    output logic [NCH-1:0]                         oclk,
    output logic [NCH-1:0]                         tick
);

    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    // Per-channel state
    logic [NCH-1:0][W-1:0] r_act_div, w_act_div_d;
    logic [NCH-1:0]        r_act_en,  w_act_en_d;
    logic [NCH-1:0][W-1:0] r_cnt,     w_cnt_d;
    logic [NCH-1:0]        r_oclk,    w_oclk_d;
    logic [NCH-1:0]        r_tick,    w_tick_d;
    logic [NCH-1:0]        r_pend,    w_pend_d;
    logic [NCH-1:0][W-1:0] r_sh_div,  w_sh_div_d;
    logic [NCH-1:0]        r_sh_en,   w_sh_en_d;

    logic [NCH-1:0]        w_run;
    logic [NCH-1:0]        w_tc;
    logic [NCH-1:0]        w_sh_run;
    logic [(1<<CW)-1:0]    w_pend_pad;
    logic                  w_accept;

    // Unused channel indices read as busy so stray writes are never accepted.
    always_comb begin
        w_pend_pad            = '1;
        w_pend_pad[NCH-1:0]   = r_pend;
    end

    assign cfg_ready = ~w_pend_pad[cfg_ch];
    assign w_accept  = cfg_valid && cfg_ready;

    always_comb begin
        w_run    = '0;
        w_tc     = '0;
        w_sh_run = '0;
        for (int i = 0; i < NCH; i++) begin
            w_run[i]    = r_act_en[i] && (r_act_div[i] != '0);
            w_tc[i]     = w_run[i] && (r_cnt[i] == (r_act_div[i] - W'(1)));
            w_sh_run[i] = r_sh_en[i] && (r_sh_div[i] != '0);
        end
    end

    always_comb begin
        w_act_div_d = r_act_div;
        w_act_en_d  = r_act_en;
        w_cnt_d     = r_cnt;
        w_oclk_d    = r_oclk;
        w_tick_d    = '0;
        w_pend_d    = r_pend;
        w_sh_div_d  = r_sh_div;
        w_sh_en_d   = r_sh_en;

        for (int i = 0; i < NCH; i++) begin
            if (start) begin
                if (r_pend[i]) begin
                    w_act_div_d[i] = r_sh_div[i];
                    w_act_en_d[i]  = r_sh_en[i];
                    w_pend_d[i]    = 1'b0;
                end
                w_cnt_d[i]  = '0;
                w_oclk_d[i] = 1'b0;
            end else if (r_pend[i] && !w_run[i]) begin
                // Idle channel: nothing to keep glitch-free, so load immediately.
                w_act_div_d[i] = r_sh_div[i];
                w_act_en_d[i]  = r_sh_en[i];
                w_pend_d[i]    = 1'b0;
                w_cnt_d[i]     = '0;
                w_oclk_d[i]    = 1'b0;
            end else if (w_tc[i]) begin
                w_cnt_d[i] = '0;
                if (r_pend[i]) begin
                    w_act_div_d[i] = r_sh_div[i];
                    w_act_en_d[i]  = r_sh_en[i];
                    w_pend_d[i]    = 1'b0;
                    if (w_sh_run[i]) begin
                        w_oclk_d[i] = ~r_oclk[i];
                        w_tick_d[i] = 1'b1;
                    end else begin
                        w_oclk_d[i] = 1'b0;
                    end
                end else begin
                    w_oclk_d[i] = ~r_oclk[i];
                    w_tick_d[i] = 1'b1;
                end
            end else if (w_run[i]) begin
                w_cnt_d[i] = r_cnt[i] + W'(1);
            end else begin
                w_cnt_d[i]  = '0;
                w_oclk_d[i] = 1'b0;
            end

            // Accepted writes only land on channels with no pending config, so the
            // shadow read above is never the one being overwritten here.
            if (w_accept && (cfg_ch == CW'(i))) begin
                w_sh_div_d[i] = cfg_div;
                w_sh_en_d[i]  = cfg_en;
                w_pend_d[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (!rst) begin
            r_act_div <= '0;
            r_act_en  <= '0;
            r_cnt     <= '0;
            r_oclk    <= '0;
            r_tick    <= '0;
            r_pend    <= '0;
            r_sh_div  <= '0;
            r_sh_en   <= '0;
        end else begin
            r_act_div <= w_act_div_d;
            r_act_en  <= w_act_en_d;
            r_cnt     <= w_cnt_d;
            r_oclk    <= w_oclk_d;
            r_tick    <= w_tick_d;
            r_pend    <= w_pend_d;
            r_sh_div  <= w_sh_div_d;
            r_sh_en   <= w_sh_en_d;
        end
    end

    assign oclk = r_oclk;
    assign tick = r_tick;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: directed vector table for basic divide/reconfigure plus hand-written
// sequences for terminal-count write timing, start alignment, disable and reset.
module tb_clkdiv_ctrl;

    logic        iclk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_en;
    logic        start;
    logic [3:0]  oclk;
    logic [3:0]  tick;

    int n_tests = 0;
    int n_fail  = 0;

    clkdiv_ctrl #(
        .NCH (4),
        .W   (16)
    ) dut (
        .iclk      (iclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .start     (start),
        .oclk      (oclk),
        .tick      (tick)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic [1:0]  ch;
        logic [15:0] div;
        logic        en;
        logic        st;
        logic [3:0]  exp_oclk;
        logic [3:0]  exp_tick;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] c,
                                input logic [15:0] d, input logic e, input logic s,
                                input logic [3:0] eo, input logic [3:0] et, input logic er);
        vec_t t;
        t.rst_n = r; t.valid = v; t.ch = c; t.div = d; t.en = e; t.st = s;
        t.exp_oclk = eo; t.exp_tick = et; t.exp_ready = er;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, and leave time 1 unit past it for sampling.
    task automatic step(input logic r, input logic v, input logic [1:0] c,
                        input logic [15:0] d, input logic e, input logic s);
        rst = r; cfg_valid = v; cfg_ch = c; cfg_div = d; cfg_en = e; start = s;
        @(posedge iclk);
        #1;
    endtask

    task automatic idle(input logic [1:0] c);
        step(1'b1, 1'b0, c, 16'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_en = 1'b0; start = 1'b0;
        #2;

        // ch0 div=3 from reset, then reconfigure to div=5 mid-period
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1);
        vecs[1]  = mk(1, 1, 0, 3, 1, 0, 4'h0, 4'h0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1);
        vecs[3]  = mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1);
        vecs[5]  = mk(1, 0, 0, 0, 0, 0, 4'h1, 4'h1, 1);
        vecs[6]  = mk(1, 0, 0, 0, 0, 0, 4'h1, 4'h0, 1);
        vecs[7]  = mk(1, 0, 0, 0, 0, 0, 4'h1, 4'h0, 1);
        vecs[8]  = mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h1, 1);
        vecs[9]  = mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1);
        vecs[10] = mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1);
        vecs[11] = mk(1, 0, 0, 0, 0, 0, 4'h1, 4'h1, 1);
        vecs[12] = mk(1, 1, 0, 5, 1, 0, 4'h1, 4'h0, 0);
        vecs[13] = mk(1, 0, 0, 0, 0, 0, 4'h1, 4'h0, 0);
        vecs[14] = mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h1, 1);
        vecs[15] = mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1);
        vecs[16] = mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1);
        vecs[17] = mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1);
        vecs[18] = mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1);
        vecs[19] = mk(1, 0, 0, 0, 0, 0, 4'h1, 4'h1, 1);

        for (int k = 0; k < 20; k++) begin
            step(vecs[k].rst_n, vecs[k].valid, vecs[k].ch, vecs[k].div, vecs[k].en,
                 vecs[k].st);
            chk($sformatf("vec%0d oclk", k), oclk, vecs[k].exp_oclk);
            chk($sformatf("vec%0d tick", k), tick, vecs[k].exp_tick);
            chk($sformatf("vec%0d ready", k), cfg_ready, vecs[k].exp_ready);
        end

        // Write landing on ch1's terminal-count cycle waits for the next terminal count
        step(1'b0, 1'b0, 2'd1, 16'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd1, 16'd2, 1'b1, 1'b0);
        idle(2'd1);
        idle(2'd1);
        idle(2'd1);
        chk("tcw first toggle", oclk[1], 1);
        idle(2'd1);
        step(1'b1, 1'b1, 2'd1, 16'd3, 1'b1, 1'b0);
        chk("tcw tc oclk", oclk[1], 0);
        chk("tcw tc tick", tick[1], 1);
        chk("tcw tc ready", cfg_ready, 0);
        idle(2'd1);
        chk("tcw hold ready", cfg_ready, 0);
        chk("tcw hold tick", tick[1], 0);
        idle(2'd1);
        chk("tcw apply oclk", oclk[1], 1);
        chk("tcw apply tick", tick[1], 1);
        chk("tcw apply ready", cfg_ready, 1);
        idle(2'd1);
        chk("tcw new cnt1", tick[1], 0);
        idle(2'd1);
        chk("tcw new cnt2", tick[1], 0);
        idle(2'd1);
        chk("tcw new tc tick", tick[1], 1);
        chk("tcw new tc oclk", oclk[1], 0);

        // start aligns ch0 div=2 and ch1 div=4; coincident write to ch2 stays pending
        step(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd0, 16'd2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd1, 16'd4, 1'b1, 1'b0);
        idle(2'd0);
        idle(2'd0);
        idle(2'd0);
        chk("start pre oclk", oclk[1:0], 2'b01);
        step(1'b1, 1'b1, 2'd2, 16'd1, 1'b1, 1'b1);
        chk("start oclk", oclk, 4'h0);
        chk("start tick", tick, 4'h0);
        chk("start ch2 ready", cfg_ready, 0);
        idle(2'd2);
        chk("start+1 tick", tick[1:0], 2'b00);
        chk("start+1 ch2 ready", cfg_ready, 1);
        idle(2'd2);
        chk("start+2 tick", tick[1:0], 2'b01);
        chk("start+2 oclk", oclk[1:0], 2'b01);
        chk("div1 first toggle", oclk[2], 1);
        idle(2'd2);
        chk("start+3 tick", tick[1:0], 2'b00);
        chk("div1 second toggle", oclk[2], 0);
        idle(2'd2);
        chk("start+4 tick", tick[1:0], 2'b11);
        chk("start+4 oclk", oclk[1:0], 2'b10);

        // Disable a high ch2 (en=0, then div=0): falls at terminal count and stays quiet
        step(1'b0, 1'b0, 2'd2, 16'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd2, 16'd2, 1'b1, 1'b0);
        idle(2'd2);
        idle(2'd2);
        idle(2'd2);
        chk("dis en high", oclk[2], 1);
        step(1'b1, 1'b1, 2'd2, 16'd2, 1'b0, 1'b0);
        chk("dis en hold", oclk[2], 1);
        chk("dis en ready", cfg_ready, 0);
        idle(2'd2);
        chk("dis en fall", oclk[2], 0);
        chk("dis en ready after", cfg_ready, 1);
        for (int k = 0; k < 6; k++) begin
            idle(2'd2);
            chk($sformatf("dis en quiet%0d", k), {oclk[2], tick[2]}, 2'b00);
        end
        step(1'b1, 1'b1, 2'd2, 16'd2, 1'b1, 1'b0);
        idle(2'd2);
        idle(2'd2);
        idle(2'd2);
        chk("dis div high", oclk[2], 1);
        step(1'b1, 1'b1, 2'd2, 16'd0, 1'b1, 1'b0);
        chk("dis div hold", oclk[2], 1);
        idle(2'd2);
        chk("dis div fall", oclk[2], 0);
        for (int k = 0; k < 6; k++) begin
            idle(2'd2);
            chk($sformatf("dis div quiet%0d", k), {oclk[2], tick[2]}, 2'b00);
        end

        // One-cycle reset mid-operation with a pending write on ch3
        step(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd0, 16'd2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd3, 16'd3, 1'b1, 1'b0);
        idle(2'd3);
        idle(2'd3);
        step(1'b1, 1'b1, 2'd3, 16'd5, 1'b1, 1'b0);
        chk("rst pre oclk0", oclk[0], 1);
        chk("rst pre ready3", cfg_ready, 0);
        step(1'b0, 1'b0, 2'd3, 16'd0, 1'b0, 1'b0);
        chk("rst oclk", oclk, 4'h0);
        chk("rst tick", tick, 4'h0);
        chk("rst ready3", cfg_ready, 1);
        for (int k = 0; k < 10; k++) begin
            idle(2'd3);
            chk($sformatf("rst quiet%0d", k), {oclk, tick}, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
